// File: rtl/alu_issue_unit.sv
// ALU issue unit: decodes a request into an ALU control code, drives operands
// for ALU_LAT cycles, then captures and holds the result until it is consumed.
module alu_issue_unit #(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  aluop_main,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_illegal
);

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state;
    logic [1:0] cnt;
    logic [3:0] dec_ctrl;
    logic       dec_illegal;

    always_comb begin
        dec_ctrl    = CTRL_ADD;
        dec_illegal = 1'b0;
        case (aluop_main)
            2'b00: dec_ctrl = CTRL_ADD;
            2'b01: dec_ctrl = CTRL_SUB;
            2'b10: begin
                case ({funct3, funct7b5})
                    4'b000_0: dec_ctrl = CTRL_ADD;
                    4'b000_1: dec_ctrl = CTRL_SUB;
                    4'b111_0: dec_ctrl = CTRL_AND;
                    4'b110_0: dec_ctrl = CTRL_OR;
                    default:  dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Handshake flags are registered alongside the state so they never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
            alu_A       <= '0;
            alu_B       <= '0;
            alu_ctrl    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (dec_illegal) begin
                            // Undecodable requests skip the ALU entirely.
                            alu_ctrl    <= 4'b0000;
                            rsp_result  <= '0;
                            rsp_zero    <= 1'b1;
                            rsp_illegal <= 1'b1;
                            rsp_valid   <= 1'b1;
                            state       <= RESP;
                        end else begin
                            alu_A    <= opA;
                            alu_B    <= opB;
                            alu_ctrl <= dec_ctrl;
                            cnt      <= 2'(ALU_LAT - 1);
                            state    <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == 2'd0) begin
                        rsp_result  <= alu_result;
                        rsp_zero    <= (alu_result == 32'd0);
                        rsp_illegal <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench: one unit at ALU_LAT=1 and one at ALU_LAT=3, each fed by a
// behavioural ALU model; every check is an immediate assertion.
module tb_alu_issue_unit;

    logic        clk = 1'b0;
    logic [1:0]  aluop_main = '0;
    logic [2:0]  funct3 = '0;
    logic        funct7b5 = 1'b0;
    logic [31:0] opA = '0, opB = '0;

    logic        rst1 = 1'b1, rv1 = 1'b0, rr1 = 1'b0;
    logic        rdy1, vld1, zero1, ill1;
    logic [31:0] a1, b1, res1, rres1;
    logic [3:0]  ctrl1;

    logic        rst3 = 1'b1, rv3 = 1'b0, rr3 = 1'b0;
    logic        rdy3, vld3, zero3, ill3;
    logic [31:0] a3, b3, res3, rres3;
    logic [3:0]  ctrl3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign res1 = alu_model(ctrl1, a1, b1);
    assign res3 = alu_model(ctrl3, a3, b3);

    alu_issue_unit #(.ALU_LAT(1)) dut1 (
        .clk(clk), .reset(rst1), .req_valid(rv1), .req_ready(rdy1),
        .aluop_main(aluop_main), .funct3(funct3), .funct7b5(funct7b5),
        .opA(opA), .opB(opB), .alu_A(a1), .alu_B(b1), .alu_ctrl(ctrl1),
        .alu_result(res1), .rsp_valid(vld1), .rsp_ready(rr1),
        .rsp_result(rres1), .rsp_zero(zero1), .rsp_illegal(ill1)
    );

    alu_issue_unit #(.ALU_LAT(3)) dut3 (
        .clk(clk), .reset(rst3), .req_valid(rv3), .req_ready(rdy3),
        .aluop_main(aluop_main), .funct3(funct3), .funct7b5(funct7b5),
        .opA(opA), .opB(opB), .alu_A(a3), .alu_B(b3), .alu_ctrl(ctrl3),
        .alu_result(res3), .rsp_valid(vld3), .rsp_ready(rr3),
        .rsp_result(rres3), .rsp_zero(zero3), .rsp_illegal(ill3)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [1:0] m, input logic [2:0] f3, input logic f7,
                          input logic [31:0] a, input logic [31:0] b);
        aluop_main = m; funct3 = f3; funct7b5 = f7; opA = a; opB = b;
    endtask

    initial begin
        // Reset both units
        step(); step();
        rst1 = 1'b0; rst3 = 1'b0;
        chk("rst_ready", 32'(rdy1), 32'd1);
        chk("rst_valid", 32'(vld1), 32'd0);
        chk("rst_ctrl", 32'(ctrl1), 32'd0);
        chk("rst_A", a1, 32'd0);
        chk("rst_B", b1, 32'd0);
        chk("rst_result", rres1, 32'd0);
        chk("rst_zero", 32'(zero1), 32'd0);
        chk("rst_illegal", 32'(ill1), 32'd0);
        chk("rst3_ready", 32'(rdy3), 32'd1);

        // R-type ADD 5+7, latency 1
        set_op(2'b10, 3'b000, 1'b0, 32'd5, 32'd7);
        rv1 = 1'b1; step(); rv1 = 1'b0;
        chk("add_ctrl", 32'(ctrl1), 32'h2);
        chk("add_A", a1, 32'd5);
        chk("add_B", b1, 32'd7);
        chk("add_ready_exec", 32'(rdy1), 32'd0);
        chk("add_valid_early", 32'(vld1), 32'd0);
        step();
        chk("add_valid", 32'(vld1), 32'd1);
        chk("add_result", rres1, 32'd12);
        chk("add_zero", 32'(zero1), 32'd0);
        chk("add_illegal", 32'(ill1), 32'd0);
        rr1 = 1'b1; step(); rr1 = 1'b0;
        chk("add_done_valid", 32'(vld1), 32'd0);
        chk("add_done_ready", 32'(rdy1), 32'd1);

        // Branch SUB with equal operands -> zero
        set_op(2'b01, 3'b101, 1'b1, 32'h1234, 32'h1234);
        rv1 = 1'b1; step(); rv1 = 1'b0;
        chk("sub_ctrl", 32'(ctrl1), 32'h6);
        step();
        chk("sub_valid", 32'(vld1), 32'd1);
        chk("sub_result", rres1, 32'd0);
        chk("sub_zero", 32'(zero1), 32'd1);
        chk("sub_illegal", 32'(ill1), 32'd0);
        rr1 = 1'b1; step(); rr1 = 1'b0;

        // Illegal R-type funct3=001 -> response next cycle
        set_op(2'b10, 3'b001, 1'b0, 32'd9, 32'd9);
        rv1 = 1'b1; step(); rv1 = 1'b0;
        chk("ill_valid", 32'(vld1), 32'd1);
        chk("ill_illegal", 32'(ill1), 32'd1);
        chk("ill_result", rres1, 32'd0);
        chk("ill_zero", 32'(zero1), 32'd1);
        chk("ill_ctrl", 32'(ctrl1), 32'h0);
        chk("ill_ready", 32'(rdy1), 32'd0);
        rr1 = 1'b1; step(); rr1 = 1'b0;
        chk("ill_done_valid", 32'(vld1), 32'd0);

        // OR with 5 cycles of backpressure; req_valid held high is ignored
        set_op(2'b10, 3'b110, 1'b0, 32'h0F00_0000, 32'h0000_0011);
        rv1 = 1'b1; step();
        chk("or_ctrl", 32'(ctrl1), 32'h1);
        set_op(2'b00, 3'b000, 1'b0, 32'hAAAA_AAAA, 32'h1);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(vld1), 32'd1);
            chk("bp_ready", 32'(rdy1), 32'd0);
            chk("bp_result", rres1, 32'h0F00_0011);
            chk("bp_A", a1, 32'h0F00_0000);
            step();
        end
        chk("bp_last_valid", 32'(vld1), 32'd1);
        rr1 = 1'b1; step(); rr1 = 1'b0;
        // Handshake edge saw req_valid=1 but must not accept it
        chk("bp_release_valid", 32'(vld1), 32'd0);
        chk("bp_release_ready", 32'(rdy1), 32'd1);
        chk("bp_no_accept_A", a1, 32'h0F00_0000);
        rv1 = 1'b0;

        // ALU_LAT=3 AND: ctrl held 3 cycles, response at N+4
        set_op(2'b10, 3'b111, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00);
        rv3 = 1'b1; step(); rv3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("and_ctrl", 32'(ctrl3), 32'h0);
            chk("and_A", a3, 32'hF0F0_F0F0);
            chk("and_valid_early", 32'(vld3), 32'd0);
            step();
        end
        chk("and_valid", 32'(vld3), 32'd1);
        chk("and_result", rres3, 32'hF000_F000);
        chk("and_zero", 32'(zero3), 32'd0);
        rr3 = 1'b1; step(); rr3 = 1'b0;

        // Reserved aluop and R-type with bad funct7 are illegal
        set_op(2'b11, 3'b000, 1'b0, 32'd1, 32'd2);
        rv3 = 1'b1; step(); rv3 = 1'b0;
        chk("rsv_valid", 32'(vld3), 32'd1);
        chk("rsv_illegal", 32'(ill3), 32'd1);
        rr3 = 1'b1; step(); rr3 = 1'b0;
        set_op(2'b10, 3'b111, 1'b1, 32'd1, 32'd2);
        rv3 = 1'b1; step(); rv3 = 1'b0;
        chk("f7_illegal", 32'(ill3), 32'd1);
        rr3 = 1'b1; step(); rr3 = 1'b0;

        // Reset in the middle of EXEC abandons the SUB
        set_op(2'b10, 3'b000, 1'b1, 32'd10, 32'd3);
        rv3 = 1'b1; step(); rv3 = 1'b0;
        step();
        chk("mid_ctrl", 32'(ctrl3), 32'h6);
        rst3 = 1'b1; rr3 = 1'b1; step(); rst3 = 1'b0; rr3 = 1'b0;
        chk("mid_rst_ready", 32'(rdy3), 32'd1);
        chk("mid_rst_valid", 32'(vld3), 32'd0);
        chk("mid_rst_ctrl", 32'(ctrl3), 32'h0);
        chk("mid_rst_A", a3, 32'd0);
        chk("mid_rst_result", rres3, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("mid_no_rsp", 32'(vld3), 32'd0);
            step();
        end

        // Reset wins over a simultaneous request
        set_op(2'b00, 3'b000, 1'b0, 32'h55, 32'h66);
        rst3 = 1'b1; rv3 = 1'b1; step(); rst3 = 1'b0; rv3 = 1'b0;
        chk("prio_ready", 32'(rdy3), 32'd1);
        chk("prio_A", a3, 32'd0);
        step();
        chk("prio_idle_valid", 32'(vld3), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
